host_mem_avalon_responder: RTL

// Avalon-MM burst responder (slave) backed by an on-chip RAM. It is the memory end of the

---
 rtl/host_mem_avalon_responder.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/host_mem_avalon_responder.sv
// Avalon-MM burst responder over on-chip RAM.
// Fixed-latency burst reads, byte-enabled burst writes, sticky protocol flag.
module host_mem_avalon_responder #(
    parameter int ADDR_WIDTH      = 10,
    parameter int DATA_WIDTH      = 512,
    parameter int BURST_CNT_WIDTH = 7,
    parameter int RD_LATENCY      = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [ADDR_WIDTH-1:0]      avs_address,
    input  logic [BURST_CNT_WIDTH-1:0] avs_burstcount,
    input  logic                       avs_read,
    input  logic                       avs_write,
    input  logic [DATA_WIDTH-1:0]      avs_writedata,
    input  logic [DATA_WIDTH/8-1:0]    avs_byteenable,
    output logic                       avs_waitrequest,
    output logic [DATA_WIDTH-1:0]      avs_readdata,
    output logic                       avs_readdatavalid,
    output logic [1:0]                 avs_response,
    output logic                       avs_writeresponsevalid,
    output logic                       protocol_err
);
    localparam int BE_W = DATA_WIDTH / 8;
    localparam logic [BURST_CNT_WIDTH-1:0] ONE = 1;

    typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST} state_t;

    state_t                     state_q, state_d;
    logic                       ready_q;
    logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
    logic [BURST_CNT_WIDTH-1:0] left_q, left_d;
    logic                       wr_rsp_q, wr_rsp_d;
    logic                       wr_err_q, wr_err_d;
    logic                       perr_q, perr_set;
    logic                       issue, issue_err;
    logic [ADDR_WIDTH-1:0]      issue_addr;
    logic                       we;
    logic [ADDR_WIDTH-1:0]      we_addr;
    logic                       zero_cnt;

    logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];
    logic [RD_LATENCY-1:0] pv, pe;
    logic [DATA_WIDTH-1:0] pd [RD_LATENCY];

    assign zero_cnt = (avs_burstcount == '0);
    assign avs_waitrequest = !ready_q || (state_q == RD_BURST);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        left_d     = left_q;
        wr_rsp_d   = 1'b0;
        wr_err_d   = 1'b0;
        perr_set   = 1'b0;
        issue      = 1'b0;
        issue_err  = 1'b0;
        issue_addr = addr_q;
        we         = 1'b0;
        we_addr    = addr_q;
        unique case (state_q)
            IDLE: begin
                // write wins over a simultaneous read
                if (ready_q && avs_write) begin
                    we       = 1'b1;
                    we_addr  = avs_address;
                    perr_set = avs_read || zero_cnt;
                    addr_d   = avs_address + 1'b1;
                    left_d   = avs_burstcount - 1'b1;
                    if (avs_burstcount > ONE) begin
                        state_d = WR_BURST;
                    end else begin
                        wr_rsp_d = 1'b1;
                        wr_err_d = zero_cnt;
                    end
                end else if (ready_q && avs_read) begin
                    issue      = 1'b1;
                    issue_addr = avs_address;
                    issue_err  = zero_cnt;
                    perr_set   = zero_cnt;
                    addr_d     = avs_address + 1'b1;
                    left_d     = avs_burstcount - 1'b1;
                    if (avs_burstcount > ONE) state_d = RD_BURST;
                end
            end
            RD_BURST: begin
                issue      = 1'b1;
                issue_addr = addr_q;
                addr_d     = addr_q + 1'b1;
                left_d     = left_q - 1'b1;
                if (left_q == ONE) state_d = IDLE;
            end
            WR_BURST: begin
                perr_set = avs_read;
                if (avs_write) begin
                    we     = 1'b1;
                    addr_d = addr_q + 1'b1;
                    left_d = left_q - 1'b1;
                    if (left_q == ONE) begin
                        state_d  = IDLE;
                        wr_rsp_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            ready_q  <= 1'b0;
            addr_q   <= '0;
            left_q   <= '0;
            wr_rsp_q <= 1'b0;
            wr_err_q <= 1'b0;
            perr_q   <= 1'b0;
            pv       <= '0;
            pe       <= '0;
            for (int i = 0; i < RD_LATENCY; i++) pd[i] <= '0;
        end else begin
            state_q  <= state_d;
            ready_q  <= 1'b1;
            addr_q   <= addr_d;
            left_q   <= left_d;
            wr_rsp_q <= wr_rsp_d;
            wr_err_q <= wr_err_d;
            perr_q   <= perr_q || perr_set;
            pv[0]    <= issue;
            pe[0]    <= issue_err;
            if (issue) pd[0] <= mem[issue_addr];
            for (int i = 1; i < RD_LATENCY; i++) begin
                pv[i] <= pv[i-1];
                pe[i] <= pe[i-1];
                pd[i] <= pd[i-1];
            end
        end
    end

    // RAM has no reset so its contents survive reset_n
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < BE_W; b++) begin
                if (avs_byteenable[b]) mem[we_addr][8*b +: 8] <= avs_writedata[8*b +: 8];
            end
        end
    end

    assign avs_readdata           = pd[RD_LATENCY-1];
    assign avs_readdatavalid      = pv[RD_LATENCY-1];
    assign avs_writeresponsevalid = wr_rsp_q;
    assign protocol_err           = perr_q;
    assign avs_response = ((avs_readdatavalid && pe[RD_LATENCY-1]) ||
                           (wr_rsp_q && wr_err_q)) ? 2'b10 : 2'b00;
endmodule
